// File: rtl/modbus_rtu_tx_framer_if.sv
// rtl/modbus_rtu_tx_framer_if.sv - payload byte stream into the Modbus RTU framer
interface modbus_rtu_tx_framer_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;

    modport master (output s_data, output s_valid, output s_last, input  s_ready);
    modport slave  (input  s_data, input  s_valid, input  s_last, output s_ready);
endinterface

// File: rtl/modbus_rtu_tx_framer.sv
// rtl/modbus_rtu_tx_framer.sv - Modbus RTU transmit framer: 8N1 UART, appended CRC-16, inter-frame silence
module modbus_rtu_tx_framer #(
    parameter int SIL_BITS = 35,
    parameter int CNT_W    = 20
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic [15:0]           baud_div,
    input  logic                  enable,
    modbus_rtu_tx_framer_if.slave s_if,
    output logic                  uart_tx_o,
    output logic                  busy,
    output logic                  frame_done,
    output logic [15:0]           crc_o
);
    localparam int SIL_W = $clog2(SIL_BITS + 1);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_WAIT, ST_SIL} state_t;
    typedef enum logic [1:0] {SRC_PAYLOAD, SRC_CRC_LO, SRC_CRC_HI} src_t;

    state_t           r_state, w_state_nxt;
    src_t             r_src, w_src_nxt;
    logic [7:0]       r_byte;
    logic             r_last;
    logic [15:0]      r_crc;
    logic [15:0]      r_div;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [SIL_W-1:0] r_sil;

    logic             w_xfer;
    logic             w_bit_end;
    logic             w_sil_end;
    logic [CNT_W-1:0] w_period_m1;
    logic [7:0]       w_tx_byte;
    logic [15:0]      w_crc_seed;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    // Gated by PRESETn so the handshake is closed while reset is held.
    assign s_if.s_ready = PRESETn && (((r_state == ST_IDLE) && enable) || (r_state == ST_WAIT));
    assign w_xfer       = s_if.s_valid && s_if.s_ready;

    assign w_period_m1 = CNT_W'({r_div, 4'b0000}) - CNT_W'(1);
    assign w_bit_end   = (r_cnt == w_period_m1);
    assign w_sil_end   = w_bit_end && (r_sil == SIL_W'(SIL_BITS - 1));
    assign w_crc_seed  = (r_state == ST_IDLE) ? 16'hFFFF : r_crc;
    assign crc_o       = r_crc;
    assign busy        = (r_state != ST_IDLE);

    always_comb begin
        w_tx_byte = r_byte;
        case (r_src)
            SRC_CRC_LO: w_tx_byte = r_crc[7:0];
            SRC_CRC_HI: w_tx_byte = r_crc[15:8];
            default:    w_tx_byte = r_byte;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= ST_IDLE;
            r_src   <= SRC_PAYLOAD;
        end else begin
            r_state <= w_state_nxt;
            r_src   <= w_src_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        frame_done  = 1'b0;
        uart_tx_o   = 1'b1;
        case (r_state)
            ST_IDLE, ST_WAIT: begin
                if (w_xfer) begin
                    w_state_nxt = ST_START;
                    w_src_nxt   = SRC_PAYLOAD;
                end
            end
            ST_START: begin
                uart_tx_o = 1'b0;
                if (w_bit_end) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                uart_tx_o = w_tx_byte[r_bit];
                if (w_bit_end && (r_bit == 3'd7)) w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    // CRC bytes follow the final payload byte with no handshake and no gap.
                    case (r_src)
                        SRC_PAYLOAD: begin
                            if (r_last) begin
                                w_state_nxt = ST_START;
                                w_src_nxt   = SRC_CRC_LO;
                            end else begin
                                w_state_nxt = ST_WAIT;
                            end
                        end
                        SRC_CRC_LO: begin
                            w_state_nxt = ST_START;
                            w_src_nxt   = SRC_CRC_HI;
                        end
                        default: w_state_nxt = ST_SIL;
                    endcase
                end
            end
            ST_SIL: begin
                if (w_sil_end) begin
                    w_state_nxt = ST_IDLE;
                    frame_done  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_byte <= 8'h00;
            r_last <= 1'b0;
            r_crc  <= 16'hFFFF;
            r_div  <= 16'd1;
            r_cnt  <= '0;
            r_bit  <= 3'd0;
            r_sil  <= '0;
        end else begin
            if (w_xfer) begin
                r_byte <= s_if.s_data;
                r_last <= s_if.s_last;
                r_crc  <= crc16_byte(w_crc_seed, s_if.s_data);
                if (r_state == ST_IDLE) r_div <= (baud_div == 16'd0) ? 16'd1 : baud_div;
            end
            // Counter reloads every bit so the frame length is an exact multiple of the bit period.
            if ((r_state == ST_IDLE) || (r_state == ST_WAIT) || w_bit_end) r_cnt <= '0;
            else                                                           r_cnt <= r_cnt + 1'b1;
            if ((r_state == ST_DATA) && w_bit_end) r_bit <= r_bit + 1'b1;
            if (r_state != ST_SIL)  r_sil <= '0;
            else if (w_bit_end)     r_sil <= r_sil + 1'b1;
        end
    end
endmodule

// File: tb/tb_modbus_rtu_tx_framer.sv
// tb/tb_modbus_rtu_tx_framer.sv - scoreboard bench for the Modbus RTU transmit framer
module tb_modbus_rtu_tx_framer;
    localparam int SIL = 35;

    logic        PCLK     = 1'b0;
    logic        PRESETn  = 1'b0;
    logic [15:0] baud_div = 16'd0;
    logic        enable   = 1'b1;
    logic        uart_tx_o, busy, frame_done;
    logic [15:0] crc_o;

    modbus_rtu_tx_framer_if sif();

    modbus_rtu_tx_framer #(.SIL_BITS(SIL), .CNT_W(20)) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .baud_div   (baud_div),
        .enable     (enable),
        .s_if       (sif),
        .uart_tx_o  (uart_tx_o),
        .busy       (busy),
        .frame_done (frame_done),
        .crc_o      (crc_o)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [7:0]  data;
        int          period;
        bit          crc_hi;
        logic [15:0] crc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic abort(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "bench stopped");
    endtask

    function automatic logic [15:0] model_crc(input logic [7:0] msg [$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (msg[i]) begin
            c = c ^ {8'h00, msg[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    // Monitor: every character is compared cycle by cycle against its 10-bit 8N1 image.
    bit          mon_active   = 1'b0;
    int          mon_t0       = 0;
    int          mon_k        = 0;
    bit          mon_err      = 1'b0;
    exp_t        mon_item;
    logic        exp_line;
    bit          done_pending = 1'b0;
    int          done_cyc     = 0;
    logic [15:0] done_crc     = 16'h0;

    always @(negedge PCLK) begin
        if (!PRESETn) begin
            mon_active   = 1'b0;
            done_pending = 1'b0;
            exp_q.delete();
        end else begin
            if (!mon_active && uart_tx_o === 1'b0) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_start: got line 0 expected 1 (cycle %0d)", cyc);
                end else begin
                    mon_item   = exp_q.pop_front();
                    mon_active = 1'b1;
                    mon_t0     = cyc;
                    mon_err    = 1'b0;
                end
            end
            if (mon_active) begin
                mon_k    = (cyc - mon_t0) / mon_item.period;
                exp_line = (mon_k == 0) ? 1'b0 : (mon_k == 9) ? 1'b1 : mon_item.data[mon_k - 1];
                if (uart_tx_o !== exp_line || sif.s_ready !== 1'b0 || busy !== 1'b1) mon_err = 1'b1;
                if (cyc - mon_t0 == 10 * mon_item.period - 1) begin
                    total++;
                    if (mon_err) begin
                        bad++;
                        $display("FAIL char_%02h: got waveform mismatch expected 8N1 with period %0d (start cycle %0d)",
                                 mon_item.data, mon_item.period, mon_t0);
                    end
                    mon_active = 1'b0;
                    if (mon_item.crc_hi) begin
                        done_pending = 1'b1;
                        done_cyc     = mon_t0 + (10 + SIL) * mon_item.period - 1;
                        done_crc     = mon_item.crc;
                    end
                end
            end
            if (frame_done === 1'b1) begin
                if (!done_pending) begin
                    total++;
                    bad++;
                    $display("FAIL frame_done_spurious: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    check("frame_done_cycle", cyc, done_cyc);
                    check("crc_o_at_done", crc_o, done_crc);
                end
                done_pending = 1'b0;
            end else if (done_pending && cyc > done_cyc) begin
                total++;
                bad++;
                $display("FAIL frame_done_missing: got 0 expected 1 at cycle %0d", done_cyc);
                done_pending = 1'b0;
            end
        end
    end

    task automatic send_frame(input logic [7:0] bytes [$], input logic [15:0] div, input int gap_after,
                              input bit drop_enable, input bit change_div);
        int          period;
        int          n;
        logic [7:0]  sofar [$];
        logic [15:0] c;
        period   = ((div == 16'd0) ? 1 : int'(div)) * 16;
        baud_div = div;
        enable   = 1'b1;
        for (int i = 0; i < bytes.size(); i++) begin
            sif.s_data  = bytes[i];
            sif.s_last  = (i == bytes.size() - 1);
            sif.s_valid = 1'b1;
            n = 0;
            forever begin
                @(negedge PCLK);
                if (sif.s_ready === 1'b1) break;
                n++;
                if (n > 20000) abort("handshake_wait");
            end
            sofar.push_back(bytes[i]);
            exp_q.push_back('{data: bytes[i], period: period, crc_hi: 1'b0, crc: 16'h0});
            if (i == bytes.size() - 1) begin
                c = model_crc(sofar);
                exp_q.push_back('{data: c[7:0],  period: period, crc_hi: 1'b0, crc: c});
                exp_q.push_back('{data: c[15:8], period: period, crc_hi: 1'b1, crc: c});
            end
            @(posedge PCLK);
            #1;
            check("crc_after_xfer", crc_o, model_crc(sofar));
            if (i == 0 && drop_enable) enable = 1'b0;
            if (i == 0 && change_div) baud_div = div + 16'd1;
            if (i == gap_after) begin
                sif.s_valid = 1'b0;
                repeat (13 * period) @(posedge PCLK);
                #1;
                check("busy_in_wait", busy, 1'b1);
                check("line_in_wait", uart_tx_o, 1'b1);
            end
        end
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
        n = 0;
        forever begin
            @(negedge PCLK);
            if (busy === 1'b0) break;
            n++;
            if (n > (bytes.size() + 2) * 10 * period + SIL * period + 100) abort("frame_end_wait");
        end
        enable = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;
    endtask

    initial begin
        #900000;
        abort("watchdog");
    end

    initial begin
        logic [7:0]  q [$];
        logic [15:0] rdiv;
        int          len;
        int          gap;

        sif.s_data  = 8'h00;
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;

        #12;
        check("rst_line", uart_tx_o, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_crc", crc_o, 16'hFFFF);
        check("rst_s_ready", sif.s_ready, 1'b0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        #1;
        check("post_rst_s_ready", sif.s_ready, 1'b1);

        enable      = 1'b0;
        sif.s_data  = 8'h55;
        sif.s_valid = 1'b1;
        repeat (4) begin
            @(negedge PCLK);
            check("s_ready_enable_low", sif.s_ready, 1'b0);
        end
        sif.s_valid = 1'b0;
        enable      = 1'b1;
        @(posedge PCLK);
        #1;

        q = '{8'h01, 8'h05, 8'h00, 8'h00, 8'hFF, 8'h00};
        send_frame(q, 16'd6, -1, 1'b0, 1'b0);
        check("crc_frame_a", crc_o, 16'h3A8C);

        send_frame(q, 16'd6, 1, 1'b0, 1'b0);
        check("crc_frame_a_gap", crc_o, 16'h3A8C);

        q = '{8'h01};
        send_frame(q, 16'd2, -1, 1'b0, 1'b0);
        check("crc_single", crc_o, 16'h807E);

        for (int f = 0; f < 6; f++) begin
            len = $urandom_range(1, 5);
            q.delete();
            for (int j = 0; j < len; j++) q.push_back(8'($urandom_range(0, 255)));
            gap  = (len >= 2 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, len - 2)) : -1;
            rdiv = 16'($urandom_range(1, 2));
            send_frame(q, rdiv, gap, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        baud_div    = 16'd2;
        sif.s_data  = 8'hA5;
        sif.s_last  = 1'b0;
        sif.s_valid = 1'b1;
        begin
            int n;
            n = 0;
            forever begin
                @(negedge PCLK);
                if (sif.s_ready === 1'b1) break;
                n++;
                if (n > 100) abort("reset_test_handshake");
            end
        end
        exp_q.push_back('{data: 8'hA5, period: 32, crc_hi: 1'b0, crc: 16'h0});
        @(posedge PCLK);
        #1;
        sif.s_valid = 1'b0;
        repeat (4 * 32 + 16) @(posedge PCLK);
        #1;
        check("pre_reset_bit3", uart_tx_o, 1'b0);
        #1;
        PRESETn = 1'b0;
        #1;
        check("reset_line_immediate", uart_tx_o, 1'b1);
        check("reset_busy_immediate", busy, 1'b0);
        check("reset_crc_immediate", crc_o, 16'hFFFF);
        check("reset_s_ready_immediate", sif.s_ready, 1'b0);
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;
        @(posedge PCLK);
        #1;

        q = '{8'h01};
        send_frame(q, 16'd0, -1, 1'b0, 1'b0);
        check("crc_after_reset_frame", crc_o, 16'h807E);
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
